// File: rtl/mem_stage_access_unit_if.sv
// Data-memory port between the MEM-stage access unit and a variable-latency memory.
// The unit (master) drives the request fields. The memory (slave) returns the
// completion and the read word.
interface mem_stage_access_unit_if;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned LaneCount = DataWidth / 8;

  logic                 memReq;
  logic                 memWe;
  logic [DataWidth-1:0] memAddr;
  logic [DataWidth-1:0] memWData;
  logic [LaneCount-1:0] memByteEn;
  logic                 memAck;
  logic [DataWidth-1:0] memRData;

  modport master (
    output memReq,
    output memWe,
    output memAddr,
    output memWData,
    output memByteEn,
    input  memAck,
    input  memRData
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  memAddr,
    input  memWData,
    input  memByteEn,
    output memAck,
    output memRData
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit. It takes one live load or store from EX/MEM and runs a
// single request/acknowledge transaction on the data-memory port. It stalls the
// pipeline while the access is outstanding. It returns sign-extended load data and
// flags illegal accesses, misaligned accesses and memory timeouts.
module mem_stage_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           inValid,
  input  logic                           inMemRead,
  input  logic                           inMemWrite,
  input  logic                           inMemByte,
  input  logic                           inMemHalf,
  input  logic [31:0]                    inAddress,
  input  logic [31:0]                    inWriteData,
  output logic                           outStall,
  output logic [31:0]                    outReadData,
  output logic                           outReadValid,
  output logic                           outMemError,
  mem_stage_access_unit_if.master        memBus
);

  localparam int unsigned DataWidth = 32;
  localparam int unsigned LaneCount = DataWidth / 8;
  localparam int unsigned CntWidth  = 8;
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } accSize_t;

  state_t               state;
  accSize_t             sizeQ;
  logic [1:0]           lowQ;
  logic [CntWidth-1:0]  waitCnt;
  logic                 memReqQ;
  logic                 memWeQ;
  logic [DataWidth-1:0] memAddrQ;
  logic [DataWidth-1:0] memWDataQ;
  logic [LaneCount-1:0] memByteEnQ;

  logic                 reqValid;
  logic                 reqIllegal;
  logic                 reqMisaligned;
  logic                 reqBad;
  accSize_t             reqSize;
  logic [LaneCount-1:0] reqByteEn;
  logic [DataWidth-1:0] reqWData;
  logic [DataWidth-1:0] rdShifted;
  logic [DataWidth-1:0] loadData;

  assign memBus.memReq    = memReqQ;
  assign memBus.memWe     = memWeQ;
  assign memBus.memAddr   = memAddrQ;
  assign memBus.memWData  = memWDataQ;
  assign memBus.memByteEn = memByteEnQ;

  // Request qualification: a byte access takes priority over a halfword access.
  always_comb begin
    reqValid = inValid & (inMemRead | inMemWrite);
    reqIllegal = inMemRead & inMemWrite;
    reqSize = SizeWord;
    if (inMemByte) begin
      reqSize = SizeByte;
    end else if (inMemHalf) begin
      reqSize = SizeHalf;
    end
    reqMisaligned = 1'b0;
    case (reqSize)
      SizeHalf: reqMisaligned = inAddress[0];
      SizeWord: reqMisaligned = (inAddress[1:0] != 2'b00);
      default:  reqMisaligned = 1'b0;
    endcase
    reqBad = reqIllegal | reqMisaligned;
  end

  // Byte lanes and lane-replicated store data for the incoming request.
  always_comb begin
    reqByteEn = 4'b1111;
    reqWData  = inWriteData;
    case (reqSize)
      SizeByte: begin
        reqByteEn = 4'b0001 << inAddress[1:0];
        reqWData  = {4{inWriteData[7:0]}};
      end
      SizeHalf: begin
        reqByteEn = inAddress[1] ? 4'b1100 : 4'b0011;
        reqWData  = {2{inWriteData[15:0]}};
      end
      default: begin
        reqByteEn = 4'b1111;
        reqWData  = inWriteData;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign-extend it to the access size.
  always_comb begin
    rdShifted = memBus.memRData >> {lowQ, 3'b000};
    case (sizeQ)
      SizeByte: loadData = {{24{rdShifted[7]}}, rdShifted[7:0]};
      SizeHalf: loadData = {{16{rdShifted[15]}}, rdShifted[15:0]};
      default:  loadData = memBus.memRData;
    endcase
  end

  // The stall comes straight from the accepting IDLE cycle so EX/MEM holds on the first cycle.
  // Reset masks it, so no stall can leak out while the unit is held in reset.
  always_comb begin
    outStall = Reset & (((state == IDLE) & reqValid) | (state == ACCESS));
  end

  // Access sequencer: state, latched request fields and registered response pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      sizeQ        <= SizeByte;
      lowQ         <= 2'b00;
      waitCnt      <= '0;
      memReqQ      <= 1'b0;
      memWeQ       <= 1'b0;
      memAddrQ     <= '0;
      memWDataQ    <= '0;
      memByteEnQ   <= '0;
      outReadData  <= '0;
      outReadValid <= 1'b0;
      outMemError  <= 1'b0;
    end else begin
      outReadValid <= 1'b0;
      outMemError  <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            if (reqBad) begin
              state        <= ERR;
              outMemError  <= 1'b1;
              outReadValid <= inMemRead;
              if (inMemRead) begin
                outReadData <= '0;
              end
            end else begin
              state      <= ACCESS;
              memReqQ    <= 1'b1;
              memWeQ     <= inMemWrite;
              memAddrQ   <= {inAddress[31:2], 2'b00};
              memWDataQ  <= reqWData;
              memByteEnQ <= reqByteEn;
              sizeQ      <= reqSize;
              lowQ       <= inAddress[1:0];
              waitCnt    <= '0;
            end
          end
        end
        ACCESS: begin
          waitCnt <= waitCnt + CntWidth'(1);
          if (memBus.memAck) begin
            state   <= RESP;
            memReqQ <= 1'b0;
            if (!memWeQ) begin
              outReadValid <= 1'b1;
              outReadData  <= loadData;
            end
          end else if (waitCnt == CntLimit) begin
            state       <= ERR;
            memReqQ     <= 1'b0;
            outMemError <= 1'b1;
            if (!memWeQ) begin
              outReadValid <= 1'b1;
              outReadData  <= '0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit. It uses a vector table of single
// transactions applied back-to-back, plus hand-written reset, hold and
// stray-acknowledge sequences.
module tb_mem_stage_access_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inMemRead = 1'b0;
  logic        inMemWrite = 1'b0;
  logic        inMemByte = 1'b0;
  logic        inMemHalf = 1'b0;
  logic [31:0] inAddress = '0;
  logic [31:0] inWriteData = '0;
  logic        outStall;
  logic [31:0] outReadData;
  logic        outReadValid;
  logic        outMemError;

  int testsRun = 0;
  int testsFailed = 0;

  mem_stage_access_unit_if memBus ();

  mem_stage_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .inValid      (inValid),
    .inMemRead    (inMemRead),
    .inMemWrite   (inMemWrite),
    .inMemByte    (inMemByte),
    .inMemHalf    (inMemHalf),
    .inAddress    (inAddress),
    .inWriteData  (inWriteData),
    .outStall     (outStall),
    .outReadData  (outReadData),
    .outReadValid (outReadValid),
    .outMemError  (outMemError),
    .memBus       (memBus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        isByte;
    logic        isHalf;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackAt;     // memReq cycle in which memAck is given, 0 = never
    int          expReq;
    int          expStall;
    logic        expErr;
    logic        chkValid;
    logic        expValid;
    logic [31:0] expData;
    logic [3:0]  expBe;
    logic [31:0] expWData;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Applies one vector starting at a negedge and returns at the negedge after its RESP/ERR cycle.
  task automatic runVec(input int idx, input vec_t v);
    int   reqCycles = 0;
    int   stallCycles = 0;
    bit   done = 0;
    logic gotValid = 1'b0;
    logic gotErr = 1'b0;
    logic [31:0] gotData = '0;
    string p = $sformatf("v%0d", idx);
    inValid     = 1'b1;
    inMemRead   = v.rd;
    inMemWrite  = v.wr;
    inMemByte   = v.isByte;
    inMemHalf   = v.isHalf;
    inAddress   = v.addr;
    inWriteData = v.wdata;
    memBus.memRData = v.rdata;
    memBus.memAck   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc == 0) begin
        check({p, ".validPulseEnded"}, 32'(outReadValid), 32'h0);
        check({p, ".errPulseEnded"}, 32'(outMemError), 32'h0);
      end
      if (outStall) stallCycles++;
      if (memBus.memReq) begin
        reqCycles++;
        check({p, ".memAddr"}, memBus.memAddr, {v.addr[31:2], 2'b00});
        check({p, ".memByteEn"}, 32'(memBus.memByteEn), 32'(v.expBe));
        check({p, ".memWe"}, 32'(memBus.memWe), 32'(v.wr));
        if (v.wr) check({p, ".memWData"}, memBus.memWData, v.expWData);
        if (reqCycles == v.ackAt) memBus.memAck = 1'b1;
      end else if (!outStall) begin
        gotValid = outReadValid;
        gotErr   = outMemError;
        gotData  = outReadData;
        done     = 1;
      end
      @(negedge Clk);
      memBus.memAck = 1'b0;
    end
    check({p, ".completed"}, 32'(done), 32'h1);
    check({p, ".reqCycles"}, 32'(reqCycles), 32'(v.expReq));
    check({p, ".stallCycles"}, 32'(stallCycles), 32'(v.expStall));
    check({p, ".memError"}, 32'(gotErr), 32'(v.expErr));
    if (v.chkValid) check({p, ".readValid"}, 32'(gotValid), 32'(v.expValid));
    if (v.chkValid && v.expValid) check({p, ".readData"}, gotData, v.expData);
  endtask

  initial begin
    memBus.memAck   = 1'b0;
    memBus.memRData = '0;

    //                 rd  wr  byte half addr          wdata          rdata          ack req stl err chk val data           be       wdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        32'h80001234, 3, 3, 4, 1'b0, 1'b1, 1'b1, 32'h80001234, 4'b1111, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h203, 32'h123456AB, 32'h0,        1, 1, 2, 1'b0, 1'b1, 1'b0, 32'h0,        4'b1000, 32'hABABABAB};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h202, 32'h0,        32'h8F7E0000, 2, 2, 3, 1'b0, 1'b1, 1'b1, 32'h0000007E, 4'b0100, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h202, 32'h0,        32'h8F7E0000, 1, 1, 2, 1'b0, 1'b1, 1'b1, 32'hFFFF8F7E, 4'b1100, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h101, 32'h0,        32'h0,        1, 0, 1, 1'b1, 1'b1, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'h0,        1, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0,        32'h00008000, 1, 1, 2, 1'b0, 1'b1, 1'b1, 32'hFFFFFF80, 4'b0010, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0,        32'h55555555, 0, 4, 5, 1'b1, 1'b1, 1'b1, 32'h0,        4'b1111, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h206, 32'h1234ABCD, 32'h0,        2, 2, 3, 1'b0, 1'b1, 1'b0, 32'h0,        4'b1100, 32'hABCDABCD};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'h11111111, 32'h0,        1, 0, 1, 1'b1, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0,        32'h12347FFF, 1, 1, 2, 1'b0, 1'b1, 1'b1, 32'h00007FFF, 4'b0011, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h304, 32'hDEADBEEF, 32'h0,        4, 4, 5, 1'b0, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF};

    // Reset state, including a live request presented while reset is held
    inValid = 1'b1;
    inMemRead = 1'b1;
    #1;
    check("rst.outStall", 32'(outStall), 32'h0);
    check("rst.memReq", 32'(memBus.memReq), 32'h0);
    check("rst.outReadData", outReadData, 32'h0);
    check("rst.outReadValid", 32'(outReadValid), 32'h0);
    check("rst.outMemError", 32'(outMemError), 32'h0);
    check("rst.memAddr", memBus.memAddr, 32'h0);
    check("rst.memByteEn", 32'(memBus.memByteEn), 32'h0);
    check("rst.memWData", memBus.memWData, 32'h0);
    check("rst.memWe", 32'(memBus.memWe), 32'h0);
    inValid = 1'b0;
    inMemRead = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // A memAck while idle must be ignored
    memBus.memAck = 1'b1;
    memBus.memRData = 32'hCAFEF00D;
    #1;
    check("idle.outStall", 32'(outStall), 32'h0);
    @(negedge Clk);
    memBus.memAck = 1'b0;
    #1;
    check("idle.strayAck.readValid", 32'(outReadValid), 32'h0);
    check("idle.strayAck.memReq", 32'(memBus.memReq), 32'h0);
    @(negedge Clk);

    // Table vectors, applied back-to-back with no idle gap between instructions
    for (int i = 0; i < 12; i++) runVec(i, vecs[i]);
    inValid = 1'b0;
    inMemRead = 1'b0;
    inMemWrite = 1'b0;
    #1;
    check("hold.afterStore.readData", outReadData, 32'h00007FFF);
    @(negedge Clk);

    // Reset arriving mid-ACCESS
    inValid = 1'b1;
    inMemRead = 1'b1;
    inMemByte = 1'b0;
    inMemHalf = 1'b0;
    inAddress = 32'h400;
    memBus.memRData = 32'h13572468;
    @(negedge Clk);
    #1;
    check("midRst.memReqBefore", 32'(memBus.memReq), 32'h1);
    #2;
    Reset = 1'b0;
    #1;
    check("midRst.memReq", 32'(memBus.memReq), 32'h0);
    check("midRst.outStall", 32'(outStall), 32'h0);
    check("midRst.memByteEn", 32'(memBus.memByteEn), 32'h0);
    check("midRst.memAddr", memBus.memAddr, 32'h0);
    inValid = 1'b0;
    inMemRead = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    memBus.memAck = 1'b1;
    @(negedge Clk);
    memBus.memAck = 1'b0;
    #1;
    check("midRst.lateAck.readValid", 32'(outReadValid), 32'h0);
    check("midRst.lateAck.memReq", 32'(memBus.memReq), 32'h0);
    check("midRst.lateAck.outStall", 32'(outStall), 32'h0);
    check("midRst.lateAck.readData", outReadData, 32'h0);
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
